// File: rtl/parallel_mem_loader.sv
//------------------------------------------------------------------------------
// Module  : parallel_mem_loader
// Brief   : Byte-wide 4-phase req/ack host loader into the data-memory write port.
//           Optional trailing XOR checksum byte: PARALLEL_LOADER_CHECKSUM_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module parallel_mem_loader #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        host_data,
  input  logic              host_req,
  output logic              host_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] word_count
);

  localparam int CNT_W = (ADDR_W > 16) ? ADDR_W + 1 : 17;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR1,
    S_ADDR0,
    S_LEN1,
    S_LEN0,
    S_DATA_LO,
    S_DATA_HI,
    S_WRITE,
    S_DONE
`ifdef PARALLEL_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_req_s;
  logic                   w_take;
  logic [15:0]            r_hdr;
  logic [15:0]            r_len;
  logic [7:0]             r_lo;
  logic [ADDR_W-1:0]      r_addr;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_last;
  logic [15:0]            w_len_full;

  assign w_req_s = r_sync[SYNC_STAGES-1];

  // A byte is taken when the synced request is high and the previous ack has
  // dropped; in 4-phase signalling that is exactly the synced rising edge.
  // WRITE and DONE hold the byte off until the FSM can consume it.
  assign w_take = w_req_s && !host_ack &&
                  (r_state != S_WRITE) && (r_state != S_DONE);

  assign w_cnt_next = CNT_W'(word_count) + CNT_W'(1);
  assign w_last     = (w_cnt_next >= CNT_W'(r_len));
  assign w_len_full = {r_len[15:8], host_data};

  assign busy = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], host_req};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_take) w_state_nxt = S_ADDR1;
      S_ADDR1:   if (w_take) w_state_nxt = S_ADDR0;
      S_ADDR0:   if (w_take) w_state_nxt = S_LEN1;
      S_LEN1:    if (w_take) w_state_nxt = S_LEN0;
      S_LEN0:    if (w_take) w_state_nxt = (w_len_full == 16'd0) ? S_DONE : S_DATA_LO;
      S_DATA_LO: if (w_take) w_state_nxt = S_DATA_HI;
      S_DATA_HI: if (w_take) w_state_nxt = S_WRITE;
`ifdef PARALLEL_LOADER_CHECKSUM_EN
      S_WRITE:   w_state_nxt = w_last ? S_CHK : S_DATA_LO;
      S_CHK:     if (w_take) w_state_nxt = S_DONE;
`else
      S_WRITE:   w_state_nxt = w_last ? S_DONE : S_DATA_LO;
`endif
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      host_ack   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      r_hdr      <= '0;
      r_len      <= '0;
      r_lo       <= '0;
      r_addr     <= '0;
    end else begin
      mem_we <= 1'b0;
      if (w_take) begin
        host_ack <= 1'b1;
      end else if (host_ack && !w_req_s) begin
        host_ack <= 1'b0;
      end
      if (w_take) begin
        case (r_state)
          S_IDLE: begin
            r_hdr      <= {8'h00, host_data};
            word_count <= '0;
          end
          S_ADDR1:   r_hdr  <= {r_hdr[7:0], host_data};
          S_ADDR0:   r_addr <= ADDR_W'({r_hdr, host_data});
          S_LEN1:    r_len  <= {host_data, 8'h00};
          S_LEN0:    r_len  <= w_len_full;
          S_DATA_LO: r_lo   <= host_data;
          S_DATA_HI: begin
            mem_we    <= 1'b1;
            mem_addr  <= r_addr;
            mem_wdata <= DATA_W'({host_data, r_lo});
          end
          default: ;
        endcase
      end
      if (r_state == S_WRITE) begin
        r_addr     <= r_addr + ADDR_W'(1);
        word_count <= word_count + ADDR_W'(1);
      end
    end
  end

`ifdef PARALLEL_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_csum <= '0;
      r_err  <= 1'b0;
    end else if (w_take) begin
      if (r_state == S_IDLE) begin
        r_csum <= host_data;
        r_err  <= 1'b0;
      end else if (r_state == S_CHK) begin
        r_err  <= (host_data != r_csum);
      end else begin
        r_csum <= r_csum ^ host_data;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/parallel_mem_loader.md
Name: parallel_mem_loader

Overview:
- Host-facing loader that writes blocks of 16-bit words into processor data memory over a byte-wide 4-phase req/ack link on gpio pins.
- It is the write-side counterpart of the parallelAddress/q memory readback path. The host loads a block, and the bench or host then reads it back through parallelAddress/q.
- Sits between the gpio pins and the data-memory secondary write port, in the processor clock domain.

Parameters:
- ADDR_W, 24, memory word address width (matches parallelAddress).
- DATA_W, 16, memory word width (matches q); fixed at 2 bytes per word.
- SYNC_STAGES, 2, flip-flop stages on host_req synchronizer (minimum 2).

Ports:
- clk  input  1  processor clock.
- rst  input  1  asynchronous reset, active-low.
- host_data  input  8  byte from host; stable while host_req is high.
- host_req  input  1  host request, asynchronous to clk.
- host_ack  output  1  byte-accepted acknowledge to host.
- mem_we  output  1  one-cycle write strobe to data memory.
- mem_addr  output  ADDR_W  write word address.
- mem_wdata  output  DATA_W  write data.
- busy  output  1  high from first header byte accepted until DONE.
- done  output  1  one-cycle pulse when a block completes.
- err  output  1  sticky error flag; cleared by the next ADDR2 byte or by reset.
- word_count  output  ADDR_W  words written in the current or last block.

Behaviour:
- Reset (rst low, async) values:
  - host_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, word_count=0.
  - FSM returns to IDLE and the synchronizer clears.
  - Reset mid-block aborts with no further writes; a partially written block is not rolled back.
- Handshake, per byte:
  - host_req passes through SYNC_STAGES flops; the rising edge is detected on the synced value.
  - On a synced rising edge, host_data is latched from the synchronized-request-qualified sample. Host guarantees data is stable for the whole req-high period.
  - host_ack rises the cycle after the edge and holds until synced host_req is seen low, then falls the next cycle.
  - No new byte is accepted while host_ack is high.
- Frame format, in byte order:
  - ADDR2, ADDR1, ADDR0: start address, MSB first; bits above ADDR_W are ignored.
  - LEN1, LEN0: word count N, MSB first.
  - Then N words, each sent low byte then high byte.
- FSM states: IDLE, ADDR1, ADDR0, LEN1, LEN0, DATA_LO, DATA_HI, WRITE, DONE; with the optional feature, also CHK.
  - IDLE: first byte is taken as ADDR2; busy=1, err=0, word_count=0.
  - ADDR1 -> ADDR0 -> LEN1 -> LEN0: one transition per accepted byte.
  - After LEN0: if N==0, go to DONE; otherwise go to DATA_LO.
  - DATA_LO: stores the low byte.
  - DATA_HI: stores the high byte, then WRITE.
  - WRITE: exactly one cycle. mem_we=1, mem_addr=current address, mem_wdata={hi,lo}. Address increments by 1 and word_count by 1. Next state is DATA_LO if word_count<N, else DONE (or CHK when the checksum feature is enabled).
  - DONE: one cycle with done=1, busy=0, then IDLE.
- Latency: mem_we asserts exactly 1 cycle after the cycle in which the high byte is latched.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Address wrap-around: an increment from 2^ADDR_W-1 goes to 0 with no error.
- Byte arriving during the WRITE or DONE cycle: it is held off, because host_ack is already up from the previous byte and the next byte cannot have been presented yet. No byte is ever dropped.

Optional Feature:
- Macro: PARALLEL_LOADER_CHECKSUM_EN.
- With the macro defined:
  - After the last word, the FSM enters CHK and accepts one additional byte.
  - The byte must equal the XOR of all preceding frame bytes (header and data).
  - On mismatch, err=1. done still pulses and the writes already performed stand.
- Without the macro: there is no CHK state, the frame ends after the last data byte, and err is tied to 0.

Test Plan:
- Header addr=0x000004, N=12, then words 5,7,13,19,23,24,2,4,6,7,9,33 -> 12 mem_we pulses at addresses 4..15 with exactly those values. word_count=12, one done pulse, and readback via parallelAddress 4..15 returns the same values.
- Header addr=0x000010, N=0 -> no mem_we, done pulses 1 cycle after LEN0 is accepted, word_count=0.
- addr=0xFFFFFE, N=3, words 0xAAAA, 0xBBBB, 0xCCCC -> writes land at 0xFFFFFE, 0xFFFFFF and 0x000000; err=0.
- Slow host (req held 20 cycles, gaps of 15 cycles) -> host_ack rises SYNC_STAGES+1 cycles after req and falls SYNC_STAGES+1 cycles after req falls. Each byte is taken once, so no duplicate or missing writes.
- rst low after the 2nd of 4 words of an addr=0x20 block -> all outputs go to their reset values immediately. Exactly 2 writes are observed, at 0x20 and 0x21, and a fresh frame afterwards loads correctly.
- With PARALLEL_LOADER_CHECKSUM_EN: correct XOR byte -> err=0. Corrupted XOR byte (value ^0x01) -> err=1 and done pulses. The next frame's ADDR2 byte clears err.
